div_share_ctrl: RTL and testbench
=================================

Name: div_share_ctrl

Overview:
- Shares one serial restoring divider core between R requesters.
- Arbitrates round-robin and accepts one request per valid/ready handshake.
- Sequences the core's enable/run window, captures the quotient and returns it with the requester id over a valid/ready response channel.
- Handles divide-by-zero locally without running the core.

Parameters:
M, 26, dividend/quotient width (matches core)
N, 14, divisor width (matches core)
R, 4, number of requesters
IDW, 2, id width, equals clog2(R)
CW, 5, run counter width; must hold M+1

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous, active-high reset
req_valid  input  R  per-requester request valid
req_ready  output  R  per-requester accept (one-hot or zero)
req_dividend  input  R*M  packed dividends, requester i at [i*M +: M]
req_divisor  input  R*N  packed divisors, requester i at [i*N +: N]
rsp_valid  output  1  result valid
rsp_ready  input  1  result consumer ready
rsp_id  output  IDW  requester index of result
rsp_quotient  output  M  quotient
rsp_dbz  output  1  divide-by-zero flag
div_en  output  1  core enable, registered; low holds the core cleared
div_dividend  output  M  core dividend, held stable while div_en is high
div_divisor  output  N  core divisor, held stable while div_en is high
div_quotient  input  M  core quotient register

Behaviour:
- Core contract: div_en low clears the core. div_en high for M+1 consecutive rising edges causes the quotient register to update on the (M+1)th edge. Operands must not change while div_en is high.
- Reset: state IDLE, rr pointer 0, div_en 0, rsp_valid 0, rsp_id 0, rsp_quotient 0, rsp_dbz 0, operand registers 0, counter 0.
- FSM states:
  - IDLE:
    - Grant g is the first index with req_valid set, searching from the rr pointer upward with wrap-around.
    - req_ready = onehot(g) combinationally, only in IDLE and only if any req_valid is set.
    - On the accept edge: latch dividend, divisor and id; set rr pointer = (g+1) mod R.
    - If divisor == 0: set rsp_quotient = all-ones, rsp_dbz = 1, go to RESP.
    - Otherwise set div_en = 1, counter = 0, go to RUN.
  - RUN: div_en = 1. The counter increments each edge. On the edge where counter == M, set div_en = 0 and go to CAPT. This gives exactly M+1 edges with div_en high.
  - CAPT: latch rsp_quotient = div_quotient, rsp_dbz = 0, go to RESP.
  - RESP: rsp_valid = 1. rsp_id, rsp_quotient and rsp_dbz are held stable. On rsp_valid & rsp_ready, go to IDLE with rsp_valid = 0.
- Latency from the accept edge to rsp_valid high:
  - Normal request: M+2 cycles (28 at defaults).
  - Divide-by-zero: 1 cycle.
- Throughput: one outstanding operation. At least one IDLE cycle between a response handshake and the next accept; req_ready is all-zero outside IDLE.
- Requester behaviour: withdrawing req_valid before accept is allowed and has no effect. A requester not granted keeps waiting; the rr pointer guarantees service within R accepts.
- rsp_ready may be high before rsp_valid; the handshake completes on the first RESP cycle.
- Asserting rst in any state returns everything to reset values at once; div_en drops asynchronously and the core is cleared on the next clock.
- Requester index wrap: pointer R-1 followed by an accept of R-1 gives pointer 0.

Decomposition:
- Package div_share_pkg:
  - state enum {IDLE, RUN, CAPT, RESP}
  - default constants M_DEF=26, N_DEF=14, R_DEF=4
  - DBZ_QUOTIENT = all-ones of M
- Sub-module rr_arbiter (R-wide):
  - Inputs: req vector, pointer.
  - Output: one-hot grant plus encoded index; purely combinational.
  - The controller owns the pointer register.

Test Plan:
- Single request on requester 2, dividend 1000000, divisor 7 -> req_ready[2] pulse, rsp_valid 28 cycles later, rsp_quotient 142857, rsp_id 2, rsp_dbz 0.
- Requester 0, dividend 67108863, divisor 16383 -> rsp_quotient 4096. div_dividend and div_divisor stay constant for all 27 div_en-high cycles.
- Requester 1, divisor 0, dividend 12345 -> no div_en pulse; rsp_valid 1 cycle after accept; rsp_quotient 0x3FFFFFF; rsp_dbz 1.
- All four req_valid held high with rsp_ready = 1 -> accept order 0,1,2,3,0. Each rsp_id matches its accept and each quotient is correct for that requester's operands.
- rsp_ready held low for 10 cycles in RESP -> rsp_valid and the payload stable throughout, req_ready all-zero, no div_en. Release gives a handshake, then IDLE.
- rst pulsed mid-RUN (counter = 10) -> div_en 0 and rsp_valid 0 immediately, state IDLE. Next request (100/3) returns 33 with full normal latency.

Source files
------------

// File: rtl/div_share_ctrl_pkg.sv
// div_share_pkg: shared types and defaults for the shared-divider controller
package div_share_pkg;
   typedef enum logic [1:0] {IDLE, RUN, CAPT, RESP} state_t;
   localparam int M_DEF = 26;
   localparam int N_DEF = 14;
   localparam int R_DEF = 4;
   localparam logic [M_DEF-1:0] DBZ_QUOTIENT = '1;
endpackage

// File: rtl/div_share_ctrl_if.sv
// div_share_ctrl_if: request, response and divider-core signals of the shared-divider controller
interface div_share_ctrl_if import div_share_pkg::*; #(
   parameter int M = M_DEF,
   parameter int N = N_DEF,
   parameter int R = R_DEF,
   parameter int IDW = 2
);
   logic [R-1:0] req_valid;
   logic [R-1:0] req_ready;
   logic [R*M-1:0] req_dividend;
   logic [R*N-1:0] req_divisor;
   logic rsp_valid;
   logic rsp_ready;
   logic [IDW-1:0] rsp_id;
   logic [M-1:0] rsp_quotient;
   logic rsp_dbz;
   logic div_en;
   logic [M-1:0] div_dividend;
   logic [N-1:0] div_divisor;
   logic [M-1:0] div_quotient;
   modport master (
      output req_valid, req_dividend, req_divisor, rsp_ready, div_quotient,
      input req_ready, rsp_valid, rsp_id, rsp_quotient, rsp_dbz, div_en, div_dividend, div_divisor
   );
   modport slave (
      input req_valid, req_dividend, req_divisor, rsp_ready, div_quotient,
      output req_ready, rsp_valid, rsp_id, rsp_quotient, rsp_dbz, div_en, div_dividend, div_divisor
   );
endinterface

// File: rtl/div_share_ctrl_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick of the first request at or above the pointer
module rr_arbiter import div_share_pkg::*; #(
   parameter int R = R_DEF,
   parameter int IDW = 2
) (
   input logic [R-1:0] req,
   input logic [IDW-1:0] ptr,
   output logic [R-1:0] grant,
   output logic [IDW-1:0] idx,
   output logic any
);
   always_comb begin
      idx = '0;
      for (int k = R - 1; k >= 0; k--)
         if (req[(int'(ptr) + k) % R]) idx = IDW'((int'(ptr) + k) % R);
      any = |req;
      grant = any ? R'(1) << idx : '0;
   end
endmodule

// File: rtl/div_share_ctrl.sv
// div_share_ctrl: shares one serial divider core between R requesters with round-robin arbitration
module div_share_ctrl import div_share_pkg::*; #(
   parameter int M = M_DEF,
   parameter int N = N_DEF,
   parameter int R = R_DEF,
   parameter int IDW = 2,
   parameter int CW = 5
) (
   input logic clk,
   input logic rst,
   div_share_ctrl_if.slave bus
);
   state_t state;
   logic [IDW-1:0] ptr;
   logic [IDW-1:0] gidx;
   logic [R-1:0] grant;
   logic any;
   logic [CW-1:0] cnt;
   logic [M-1:0] gdvd;
   logic [N-1:0] gdvs;
   rr_arbiter #(.R(R), .IDW(IDW)) u_arb (
      .req(bus.req_valid),
      .ptr(ptr),
      .grant(grant),
      .idx(gidx),
      .any(any)
   );
   assign bus.req_ready = (state == IDLE && any) ? grant : '0;
   assign gdvd = bus.req_dividend[int'(gidx)*M +: M];
   assign gdvs = bus.req_divisor[int'(gidx)*N +: N];
   // div_en stays high from the accept edge through the edge where cnt reaches M: M+1 core edges
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         ptr <= '0;
         cnt <= '0;
         bus.div_en <= 1'b0;
         bus.div_dividend <= '0;
         bus.div_divisor <= '0;
         bus.rsp_valid <= 1'b0;
         bus.rsp_id <= '0;
         bus.rsp_quotient <= '0;
         bus.rsp_dbz <= 1'b0;
      end else begin
         case (state)
            IDLE: if (any) begin
               bus.div_dividend <= gdvd;
               bus.div_divisor <= gdvs;
               bus.rsp_id <= gidx;
               ptr <= IDW'((int'(gidx) + 1) % R);
               if (gdvs == '0) begin
                  bus.rsp_quotient <= '1;
                  bus.rsp_dbz <= 1'b1;
                  bus.rsp_valid <= 1'b1;
                  state <= RESP;
               end else begin
                  bus.div_en <= 1'b1;
                  cnt <= '0;
                  state <= RUN;
               end
            end
            RUN: begin
               cnt <= cnt + 1'b1;
               if (cnt == CW'(M)) begin
                  bus.div_en <= 1'b0;
                  state <= CAPT;
               end
            end
            CAPT: begin
               bus.rsp_quotient <= bus.div_quotient;
               bus.rsp_dbz <= 1'b0;
               bus.rsp_valid <= 1'b1;
               state <= RESP;
            end
            RESP: if (bus.rsp_ready) begin
               bus.rsp_valid <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_div_share_ctrl.sv
// tb_div_share_ctrl: vector table, corner sequences and randomized checks against a reference model
module tb_div_share_ctrl import div_share_pkg::*;;
   localparam int M = M_DEF;
   localparam int N = N_DEF;
   localparam int R = R_DEF;
   localparam int IDW = 2;
   localparam int CW = 5;

   typedef struct {
      int id;
      logic [M-1:0] a;
      logic [N-1:0] b;
      int hold;
      logic [M-1:0] q;
      logic dbz;
   } vec_t;

   typedef struct {
      int id;
      logic [M-1:0] q;
      logic dbz;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic [R-1:0] rv = '0;
   logic [M-1:0] opa [R];
   logic [N-1:0] opb [R];
   int errors = 0;
   int checks = 0;

   div_share_ctrl_if #(.M(M), .N(N), .R(R), .IDW(IDW)) bus ();

   div_share_ctrl #(.M(M), .N(N), .R(R), .IDW(IDW), .CW(CW)) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus.slave)
   );

   always #5 clk = ~clk;

   assign bus.req_valid = rv;
   for (genvar i = 0; i < R; i++) begin : g_pack
      assign bus.req_dividend[i*M +: M] = opa[i];
      assign bus.req_divisor[i*N +: N] = opb[i];
   end

   // Core model: quotient appears on the (M+1)th consecutive enabled edge, cleared while disabled
   logic [M-1:0] core_q = '0;
   logic [M-1:0] pa = '0;
   logic [N-1:0] pb = '0;
   int ec = 0;
   int en_total = 0;
   int chg_total = 0;
   always @(posedge clk) begin
      if (!bus.div_en) begin
         ec <= 0;
         core_q <= '0;
      end else begin
         en_total <= en_total + 1;
         if (ec > 0 && (bus.div_dividend !== pa || bus.div_divisor !== pb)) chg_total <= chg_total + 1;
         pa <= bus.div_dividend;
         pb <= bus.div_divisor;
         ec <= ec + 1;
         if (ec == M)
            core_q <= (bus.div_divisor == '0) ? '1 : bus.div_dividend / {{(M-N){1'b0}}, bus.div_divisor};
      end
   end
   assign bus.div_quotient = core_q;

   function automatic logic [M-1:0] ref_q(input logic [M-1:0] a, input logic [N-1:0] b);
      return (b == '0) ? DBZ_QUOTIENT : a / {{(M-N){1'b0}}, b};
   endfunction

   task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, want %0h", n, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic reset_dut();
      rst = 1'b1;
      rv = '0;
      step();
      step();
      rst = 1'b0;
   endtask

   task automatic run_vec(input vec_t v);
      int t, lat, e0, c0, o;
      logic [IDW-1:0] id0;
      logic [M-1:0] q0;
      logic dbz0;
      rv[v.id] = 1'b1;
      opa[v.id] = v.a;
      opb[v.id] = v.b;
      bus.rsp_ready = (v.hold == 0);
      #1;
      t = 0;
      while (bus.req_ready == '0 && t < 50) begin step(); t++; end
      chk("grant", 64'(bus.req_ready), 64'(R'(1) << v.id));
      e0 = en_total;
      c0 = chg_total;
      step();
      rv[v.id] = 1'b0;
      lat = 0;
      while (!bus.rsp_valid && lat < 100) begin step(); lat++; end
      chk("latency", 64'(lat), 64'(v.dbz ? 0 : M + 2));
      chk("en_edges", 64'(en_total - e0), 64'(v.dbz ? 0 : M + 1));
      chk("op_stable", 64'(chg_total - c0), 64'(0));
      chk("rsp_id", 64'(bus.rsp_id), 64'(v.id));
      chk("rsp_q", 64'(bus.rsp_quotient), 64'(v.q));
      chk("rsp_dbz", 64'(bus.rsp_dbz), 64'(v.dbz));
      id0 = bus.rsp_id;
      q0 = bus.rsp_quotient;
      dbz0 = bus.rsp_dbz;
      if (v.hold > 0) begin
         o = (v.id + 1) % R;
         rv[o] = 1'b1;
         opa[o] = 26'd777;
         opb[o] = 14'd5;
         for (int i = 0; i < v.hold; i++) begin
            step();
            chk("hold_valid", 64'(bus.rsp_valid), 64'(1));
            chk("hold_payload", 64'({bus.rsp_id, bus.rsp_quotient, bus.rsp_dbz}), 64'({id0, q0, dbz0}));
            chk("hold_ready", 64'(bus.req_ready), 64'(0));
            chk("hold_en", 64'(bus.div_en), 64'(0));
         end
         rv[o] = 1'b0;
         bus.rsp_ready = 1'b1;
      end
      step();
      chk("rsp_drop", 64'(bus.rsp_valid), 64'(0));
   endtask

   vec_t vt [7];
   vec_t vm;

   initial begin
      int t, g, mptr, acc;
      logic idle, hs;
      logic [R-1:0] eg;
      exp_t e;
      exp_t q_exp [$];
      for (int i = 0; i < R; i++) begin opa[i] = '0; opb[i] = '0; end
      bus.rsp_ready = 1'b0;
      vt[0] = '{2, 26'd1000000, 14'd7, 0, 26'd142857, 1'b0};
      vt[1] = '{0, 26'd67108863, 14'd16383, 0, 26'd4096, 1'b0};
      vt[2] = '{1, 26'd12345, 14'd0, 0, 26'h3FFFFFF, 1'b1};
      vt[3] = '{3, 26'd99999, 14'd100, 10, 26'd999, 1'b0};
      vt[4] = '{0, 26'd0, 14'd5, 0, 26'd0, 1'b0};
      vt[5] = '{3, 26'h3FFFFFF, 14'd1, 0, 26'h3FFFFFF, 1'b0};
      vt[6] = '{2, 26'd5, 14'd9, 0, 26'd0, 1'b0};
      vm = '{3, 26'd100, 14'd3, 0, 26'd33, 1'b0};

      step();
      chk("rst_en", 64'(bus.div_en), 64'(0));
      chk("rst_valid", 64'(bus.rsp_valid), 64'(0));
      chk("rst_payload", 64'({bus.rsp_id, bus.rsp_quotient, bus.rsp_dbz}), 64'(0));
      chk("rst_operands", 64'({bus.div_dividend, bus.div_divisor}), 64'(0));
      chk("rst_ready", 64'(bus.req_ready), 64'(0));
      rst = 1'b0;

      foreach (vt[i]) run_vec(vt[i]);

      // Abort an operation at counter 10; pointer 3 before reset must return to 0
      rv[2] = 1'b1;
      opa[2] = 26'd5000;
      opb[2] = 14'd7;
      #1;
      t = 0;
      while (bus.req_ready == '0 && t < 50) begin step(); t++; end
      chk("mid_grant", 64'(bus.req_ready), 64'(4'b0100));
      step();
      rv[2] = 1'b0;
      repeat (10) step();
      chk("mid_run_en", 64'(bus.div_en), 64'(1));
      rv = 4'b1010;
      rst = 1'b1;
      #1;
      chk("mid_rst_en", 64'(bus.div_en), 64'(0));
      chk("mid_rst_valid", 64'(bus.rsp_valid), 64'(0));
      chk("mid_rst_idle", 64'(bus.req_ready), 64'(4'b0010));
      rv = '0;
      step();
      rst = 1'b0;
      run_vec(vm);

      reset_dut();
      bus.rsp_ready = 1'b1;
      for (int i = 0; i < R; i++) begin
         rv[i] = 1'b1;
         opa[i] = M'($urandom);
         opb[i] = N'($urandom_range(1, 16383));
      end
      #1;
      for (int n = 0; n < 5; n++) begin
         t = 0;
         while (bus.req_ready == '0 && t < 50) begin step(); t++; end
         chk("rr_order", 64'(bus.req_ready), 64'(R'(1) << (n % R)));
         e.q = ref_q(opa[n % R], opb[n % R]);
         step();
         t = 0;
         while (!bus.rsp_valid && t < 100) begin step(); t++; end
         chk("rr_id", 64'(bus.rsp_id), 64'(n % R));
         chk("rr_q", 64'(bus.rsp_quotient), 64'(e.q));
         step();
      end
      rv = '0;

      reset_dut();
      mptr = 0;
      idle = 1'b1;
      hs = 1'b0;
      acc = -1;
      for (int c = 0; c < 2500; c++) begin
         step();
         if (hs) begin idle = 1'b1; hs = 1'b0; end
         if (acc >= 0) begin rv[acc] = 1'b0; acc = -1; end
         for (int i = 0; i < R; i++)
            if (!rv[i]) begin
               if ($urandom_range(0, 3) == 0) begin
                  rv[i] = 1'b1;
                  opa[i] = M'($urandom);
                  opb[i] = ($urandom_range(0, 7) == 0) ? '0 :
                           ($urandom_range(0, 1) == 0) ? N'($urandom_range(1, 20)) : N'($urandom_range(1, 16383));
               end
            end else if ($urandom_range(0, 15) == 0) rv[i] = 1'b0;
         bus.rsp_ready = 1'($urandom_range(0, 1));
         #1;
         g = -1;
         if (idle)
            for (int k = 0; k < R && g < 0; k++)
               if (rv[(mptr + k) % R]) g = (mptr + k) % R;
         eg = (g >= 0) ? R'(1) << g : '0;
         chk("rand_grant", 64'(bus.req_ready), 64'(eg));
         if (g >= 0) begin
            q_exp.push_back('{g, ref_q(opa[g], opb[g]), opb[g] == '0});
            mptr = (g + 1) % R;
            idle = 1'b0;
            acc = g;
         end
         if (bus.rsp_valid && bus.rsp_ready) begin
            chk("rand_pending", 64'(q_exp.size()), 64'(1));
            if (q_exp.size() > 0) begin
               e = q_exp.pop_front();
               chk("rand_id", 64'(bus.rsp_id), 64'(e.id));
               chk("rand_q", 64'(bus.rsp_quotient), 64'(e.q));
               chk("rand_dbz", 64'(bus.rsp_dbz), 64'(e.dbz));
            end
            hs = 1'b1;
         end
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #800000;
      $display("FAIL watchdog: simulation did not complete, errors=%0d", errors);
      $fatal(1);
   end
endmodule
